// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the scoreboard entry layout, the register-file forward code and parameter-range checks.
package hazard_pkg;

  localparam int MAX_REG_AW  = 16;
  localparam int FWD_REGFILE = 0;
  localparam int DEPTH_MIN   = 2;
  localparam int DEPTH_MAX   = 8;

  // rd is stored zero-extended so one struct type serves every REG_AW.
  typedef struct packed {
    logic                  valid;
    logic [MAX_REG_AW-1:0] rd;
    logic                  regwrite;
    logic                  memread;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '0;

  function automatic bit params_ok(input int depth, input int load_fwd_stage, input int reg_aw);
    return (depth >= DEPTH_MIN) && (depth <= DEPTH_MAX) &&
           (load_fwd_stage >= 2) && (load_fwd_stage <= depth) &&
           (reg_aw >= 1) && (reg_aw <= MAX_REG_AW);
  endfunction

endpackage

// File: rtl/hazard_pipe_ctrl_if.sv
// Decode-stage inputs and pipeline-register controls of the hazard controller.
// master drives the ID fields, branch and freeze; slave is the controller.
interface hazard_pipe_ctrl_if #(
  parameter int DEPTH  = 3,
  parameter int REG_AW = 5
);
  localparam int FW = $clog2(DEPTH + 1);

  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_rs1_used;
  logic              id_rs2_used;
  logic              id_regwrite;
  logic              id_memread;
  logic              branch_taken_ex;
  logic              freeze;

  logic              pc_write_en;
  logic              ifid_write_en;
  logic              ifid_flush;
  logic              idex_bubble;
  logic [FW-1:0]     fwd_a;
  logic [FW-1:0]     fwd_b;
  logic [31:0]       stall_count;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_rs1_used, id_rs2_used,
           id_regwrite, id_memread, branch_taken_ex, freeze,
    input  pc_write_en, ifid_write_en, ifid_flush, idex_bubble,
           fwd_a, fwd_b, stall_count
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_rs1_used, id_rs2_used,
           id_regwrite, id_memread, branch_taken_ex, freeze,
    output pc_write_en, ifid_write_en, ifid_flush, idex_bubble,
           fwd_a, fwd_b, stall_count
  );

endinterface

// File: rtl/hazard_src_match.sv
// Matches one ID source register against the scoreboard.
// Reports a load-use hazard and the youngest forwardable stage for the next EX cycle.
module hazard_src_match
  import hazard_pkg::*;
#(
  parameter int DEPTH          = 3,
  parameter int LOAD_FWD_STAGE = 3,
  parameter int REG_AW         = 5,
  localparam int FW            = $clog2(DEPTH + 1)
) (
  input  logic [REG_AW-1:0] src,
  input  logic              used,
  input  sb_entry_t         sb [1:DEPTH],
  output logic              load_hit,
  output logic [FW-1:0]     fwd_sel
);

  logic [DEPTH:1] match;

  always_comb begin
    match    = '0;
    load_hit = 1'b0;
    fwd_sel  = FW'(FWD_REGFILE);
    for (int k = 1; k <= DEPTH; k++) begin
      match[k] = used && sb[k].valid && sb[k].regwrite &&
                 (sb[k].rd == MAX_REG_AW'(src)) && (src != '0);
    end
    for (int k = 1; k <= DEPTH; k++) begin
      if (match[k] && sb[k].memread && ((k + 1) < LOAD_FWD_STAGE)) load_hit = 1'b1;
    end
    // Walk oldest to youngest so the youngest producer wins; s[k] sits in stage k+1 next cycle.
    for (int k = DEPTH - 1; k >= 1; k--) begin
      if (match[k]) fwd_sel = FW'(k + 1);
    end
  end

endmodule

// File: rtl/hazard_pipe_ctrl.sv
// In-order pipeline hazard controller: load-use stalls, branch flushes, global freeze
// and registered EX operand forwarding selects driven from a destination scoreboard.
module hazard_pipe_ctrl
  import hazard_pkg::*;
#(
  parameter int DEPTH          = 3,
  parameter int LOAD_FWD_STAGE = 3,
  parameter int REG_AW         = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  hazard_pipe_ctrl_if.slave    bus
);

  localparam int FW = $clog2(DEPTH + 1);

  generate
    if (!params_ok(DEPTH, LOAD_FWD_STAGE, REG_AW)) begin : g_bad_params
      $error("hazard_pipe_ctrl: DEPTH/LOAD_FWD_STAGE/REG_AW out of range");
    end
  endgenerate

  sb_entry_t     sb [1:DEPTH];
  sb_entry_t     id_entry;
  logic          load_a, load_b, load_use;
  logic [FW-1:0] sel_a, sel_b;
  logic [FW-1:0] fwd_a_q, fwd_b_q;
  logic [31:0]   stall_cnt_q;
  logic          pc_we, ifid_we, flush, bubble;

  hazard_src_match #(.DEPTH(DEPTH), .LOAD_FWD_STAGE(LOAD_FWD_STAGE), .REG_AW(REG_AW)) u_match_rs1 (
    .src      (bus.id_rs1),
    .used     (bus.id_valid & bus.id_rs1_used),
    .sb       (sb),
    .load_hit (load_a),
    .fwd_sel  (sel_a)
  );

  hazard_src_match #(.DEPTH(DEPTH), .LOAD_FWD_STAGE(LOAD_FWD_STAGE), .REG_AW(REG_AW)) u_match_rs2 (
    .src      (bus.id_rs2),
    .used     (bus.id_valid & bus.id_rs2_used),
    .sb       (sb),
    .load_hit (load_b),
    .fwd_sel  (sel_b)
  );

  assign load_use = load_a | load_b;

  always_comb begin
    id_entry          = SB_EMPTY;
    id_entry.valid    = bus.id_valid;
    id_entry.rd       = MAX_REG_AW'(bus.id_rd);
    id_entry.regwrite = bus.id_regwrite;
    id_entry.memread  = bus.id_memread;
  end

  // Priority: freeze holds everything, then a taken branch squashes, then load-use stalls.
  always_comb begin
    pc_we   = 1'b1;
    ifid_we = 1'b1;
    flush   = 1'b0;
    bubble  = 1'b0;
    if (bus.freeze) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
    end else if (bus.branch_taken_ex) begin
      flush   = 1'b1;
      bubble  = 1'b1;
    end else if (load_use) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
      bubble  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 1; k <= DEPTH; k++) sb[k] <= SB_EMPTY;
      fwd_a_q     <= FW'(FWD_REGFILE);
      fwd_b_q     <= FW'(FWD_REGFILE);
      stall_cnt_q <= '0;
    end else if (!bus.freeze) begin
      sb[1] <= bubble ? SB_EMPTY : id_entry;
      for (int k = 2; k <= DEPTH; k++) sb[k] <= sb[k-1];
      fwd_a_q <= sel_a;
      fwd_b_q <= sel_b;
      if (load_use && !bus.branch_taken_ex && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign bus.pc_write_en   = pc_we;
  assign bus.ifid_write_en = ifid_we;
  assign bus.ifid_flush    = flush;
  assign bus.idex_bubble   = bubble;
  assign bus.fwd_a         = fwd_a_q;
  assign bus.fwd_b         = fwd_b_q;
  assign bus.stall_count   = stall_cnt_q;

endmodule

// File: doc/hazard_pipe_ctrl.md
HAZARD_PIPE_CTRL -- requirements
Module: hazard_pipe_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 3, meaning tracked post-ID stages (1=EX, 2=MEM, 3=WB, ...); legal range 2..8.
REQ-002 SHALL have parameter LOAD_FWD_STAGE, default 3, meaning the first stage whose load data is forwardable; legal range 2..DEPTH.
REQ-003 SHALL have parameter REG_AW, default 5, meaning register address width.
REQ-004 SHALL have clk  input  1  the single clock.
REQ-005 SHALL have rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have id_valid  input  1  ID holds a real instruction.
REQ-007 SHALL have id_rs1, id_rs2, id_rd  input  REG_AW each  ID source and destination registers.
REQ-008 SHALL have id_rs1_used, id_rs2_used, id_regwrite, id_memread  input  1 each  ID decode flags.
REQ-009 SHALL have branch_taken_ex  input  1  branch in EX redirects the PC this cycle.
REQ-010 SHALL have freeze  input  1  external global stall (memory not ready).
REQ-011 SHALL have pc_write_en, ifid_write_en, ifid_flush, idex_bubble  output  1 each  pipeline register controls.
REQ-012 SHALL have fwd_a, fwd_b  output  FW=$clog2(DEPTH+1)  EX operand source: 0 = register file, k = stage k (2..DEPTH).
REQ-013 SHALL have stall_count  output  32  load-use stall cycles since reset.

Function
REQ-014 SHALL keep a scoreboard s[1..DEPTH], each entry holding valid, rd, regwrite, memread; s[1] describes EX.
REQ-015 On an advancing cycle (freeze=0), s[k] <= s[k-1] for k>=2 and s[1] <= ID fields, or an invalid entry if idex_bubble=1.
REQ-016 An entry matches source r iff valid & regwrite & rd==r & r!=0 & the source's used flag=1.
REQ-017 load_use SHALL be 1 when a source matches some s[k] with memread=1 and k+1 < LOAD_FWD_STAGE.
REQ-018 fwd_a/fwd_b SHALL be registered: on an advancing cycle they load the stage (k+1) of the lowest-k match in s[1..DEPTH-1], else 0; they are valid for the instruction then in EX.
REQ-019 On load_use with no branch: pc_write_en=0, ifid_write_en=0, idex_bubble=1, ifid_flush=0; stall persists until the condition clears (LOAD_FWD_STAGE=3 gives exactly 1 cycle).
REQ-020 On branch_taken_ex=1: ifid_flush=1, idex_bubble=1, pc_write_en=1, ifid_write_en=1, same cycle (combinational); branch has priority over load_use.
REQ-021 With freeze=1, the scoreboard, fwd_a/fwd_b and stall_count SHALL hold; pc_write_en=ifid_write_en=0, ifid_flush=idex_bubble=0.
REQ-022 Otherwise all enables SHALL be 1 and flush/bubble 0.
REQ-023 stall_count SHALL increment once per advancing cycle with load_use=1 and branch_taken_ex=0, saturating at 32'hFFFF_FFFF.
REQ-024 id_valid=0 SHALL never match or stall; an invalid ID entry enters s[1] as invalid.

Reset
REQ-025 While rst=1 at a clk edge: all scoreboard valid bits 0, fwd_a=fwd_b=0, stall_count=0; rst overrides freeze.
REQ-026 After reset, combinational outputs SHALL be pc_write_en=1, ifid_write_en=1, ifid_flush=0, idex_bubble=0 (freeze=0, branch=0).
REQ-027 Reset mid-stall SHALL cancel the stall at the next edge, with no residual bubble.

Structure
REQ-028 Package hazard_pkg SHALL hold the scoreboard entry struct, the FWD_REGFILE=0 constant, and parameter-range checks.
REQ-029 One sub-module, hazard_src_match, SHALL compute per-source match vector and lowest-k select; it is instantiated twice (rs1, rs2).

Verification
REQ-030 lw x5 then add x6,x5,x7 (DEFAULTS) -> one cycle pc_write_en=0, idex_bubble=1; then fwd_a=3 for add in EX; stall_count=1.
REQ-031 add x5 then sub x8,x7,x5 -> no stall; fwd_b=2 with sub in EX; add x5; nop; sub x5 use -> fwd=3.
REQ-032 Writes to x5 in s[1] and s[2] both match -> fwd selects youngest (2); writes to x0 -> fwd=0, no stall.
REQ-033 load_use and branch_taken_ex same cycle -> ifid_flush=1, idex_bubble=1, pc_write_en=1, stall_count unchanged.
REQ-034 freeze=1 for 4 cycles during load_use -> all held, stall_count unchanged; release -> single stall completes.
REQ-035 DEPTH=5, LOAD_FWD_STAGE=4, lw x5 then immediate use -> 2 stall cycles, then fwd_a=4; rst asserted in the 2nd stall -> next cycle all enables 1, stall_count=0.
